// File: rtl/cdc_pkg.sv
// Shared definitions for the multi-bit CDC receive controller: FSM encoding,
// enable-mode selectors and the FSM state record.
package cdc_pkg;

   localparam int MODE_LEVEL  = 0;
   localparam int MODE_TOGGLE = 1;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   // FSM state and sticky overrun kept together so checkers can bind to one record
   typedef struct packed {
      state_t state;
      logic   overrun;
   } fsm_t;

endpackage

// File: rtl/en_sync.sv
// Single-bit multi-flop synchronizer, reset to 0, for the source enable.
module en_sync #(
   parameter int NUM_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic [NUM_STAGES-1:0] sync_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], D};
      end
   end

   assign Q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_ctrl.sv
// Receive-side controller for a multi-bit CDC path: synchronizes the source
// enable, captures the quasi-static bus on each event, hands it out via valid/ready.
//
// Handshake: a word is transferred at a rising CLK edge where SYNC_VALID and
// SYNC_READY are both 1; SYNC_VALID stays high until that edge, SYNC_READY is
// ignored while SYNC_VALID is low.
module data_sync_ctrl
   import cdc_pkg::*;
#(
   parameter int NUM_STAGES  = 2,
   parameter int BUS_WIDTH   = 8,
   parameter int TOGGLE_MODE = MODE_LEVEL
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
   input  logic                 BUS_ENABLE,
   output logic [BUS_WIDTH-1:0] SYNC_BUS,
   output logic                 ENABLE_PULSE,
   output logic                 SYNC_VALID,
   input  logic                 SYNC_READY,
   output logic                 OVERRUN,
   input  logic                 OVR_CLR
);

   localparam int BW = $clog2(NUM_STAGES + 2);
   localparam logic [BW-1:0] BLANK_END = BW'(NUM_STAGES + 1);

   logic          sync_en;
   logic          en_d;
   logic          raw_evt;
   logic          evt;
   logic          armed;
   logic [BW-1:0] blank_cnt;
   fsm_t          fsm_q;

   en_sync #(
      .NUM_STAGES(NUM_STAGES)
   ) u_en_sync (
      .CLK(CLK),
      .RST(RST),
      .D  (BUS_ENABLE),
      .Q  (sync_en)
   );

   // After reset the chain refills from 0; an enable already high at release
   // would look like a fresh edge, so events stay masked until the chain has
   // settled and en_d has caught up with it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         en_d      <= 1'b0;
         blank_cnt <= '0;
      end else begin
         en_d <= sync_en;
         if (!armed) begin
            blank_cnt <= blank_cnt + BW'(1);
         end
      end
   end

   assign armed   = (blank_cnt == BLANK_END);
   assign raw_evt = (TOGGLE_MODE == MODE_TOGGLE) ? (sync_en ^ en_d) : (sync_en & ~en_d);
   assign evt     = raw_evt & armed;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         fsm_q        <= '{state: IDLE, overrun: 1'b0};
         SYNC_BUS     <= '0;
         ENABLE_PULSE <= 1'b0;
         SYNC_VALID   <= 1'b0;
      end else begin
         ENABLE_PULSE <= 1'b0;
         // Clear first so a drop in the same cycle overrides it
         if (OVR_CLR) begin
            fsm_q.overrun <= 1'b0;
         end
         case (fsm_q.state)
            IDLE: begin
               if (evt) begin
                  SYNC_BUS     <= UNSYNC_BUS;
                  ENABLE_PULSE <= 1'b1;
                  SYNC_VALID   <= 1'b1;
                  fsm_q.state  <= FULL;
               end
            end
            FULL: begin
               if (evt && SYNC_READY) begin
                  SYNC_BUS     <= UNSYNC_BUS;
                  ENABLE_PULSE <= 1'b1;
               end else if (evt) begin
                  fsm_q.overrun <= 1'b1;
               end else if (SYNC_READY) begin
                  SYNC_VALID  <= 1'b0;
                  fsm_q.state <= IDLE;
               end
            end
            default: begin
               SYNC_VALID  <= 1'b0;
               fsm_q.state <= IDLE;
            end
         endcase
      end
   end

   assign OVERRUN = fsm_q.overrun;

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Bench for data_sync_ctrl: level mode (2 and 3 stages) and toggle mode instances
// sharing one clock and reset, with a captured-word scoreboard per instance.
module tb_data_sync_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // level mode, 2 stages
   logic [7:0] l_bus, l_sbus;
   logic       l_en, l_rdy, l_clr, l_pulse, l_valid, l_ovr;
   // toggle mode, 2 stages
   logic [7:0] t_bus, t_sbus;
   logic       t_en, t_rdy, t_clr, t_pulse, t_valid, t_ovr;
   // level mode, 3 stages
   logic [7:0] n_bus, n_sbus;
   logic       n_en, n_rdy, n_clr, n_pulse, n_valid, n_ovr;

   int total = 0;
   int bad   = 0;
   logic [7:0] l_q[$];
   logic [7:0] t_q[$];
   logic [7:0] n_q[$];
   int l_pcnt = 0;
   int t_pcnt = 0;
   int n_pcnt = 0;

   data_sync_ctrl #(.NUM_STAGES(2), .BUS_WIDTH(8), .TOGGLE_MODE(0)) dut_l (
      .CLK(clk), .RST(rst_n), .UNSYNC_BUS(l_bus), .BUS_ENABLE(l_en), .SYNC_BUS(l_sbus),
      .ENABLE_PULSE(l_pulse), .SYNC_VALID(l_valid), .SYNC_READY(l_rdy), .OVERRUN(l_ovr),
      .OVR_CLR(l_clr));

   data_sync_ctrl #(.NUM_STAGES(2), .BUS_WIDTH(8), .TOGGLE_MODE(1)) dut_t (
      .CLK(clk), .RST(rst_n), .UNSYNC_BUS(t_bus), .BUS_ENABLE(t_en), .SYNC_BUS(t_sbus),
      .ENABLE_PULSE(t_pulse), .SYNC_VALID(t_valid), .SYNC_READY(t_rdy), .OVERRUN(t_ovr),
      .OVR_CLR(t_clr));

   data_sync_ctrl #(.NUM_STAGES(3), .BUS_WIDTH(8), .TOGGLE_MODE(0)) dut_n (
      .CLK(clk), .RST(rst_n), .UNSYNC_BUS(n_bus), .BUS_ENABLE(n_en), .SYNC_BUS(n_sbus),
      .ENABLE_PULSE(n_pulse), .SYNC_VALID(n_valid), .SYNC_READY(n_rdy), .OVERRUN(n_ovr),
      .OVR_CLR(n_clr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drivers and direct checks act 1 time unit after each rising edge
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic pick_pulse(input int which);
      case (which)
         0:       return l_pulse;
         1:       return t_pulse;
         default: return n_pulse;
      endcase
   endfunction

   // Returns the number of edges taken for a pulse to appear, 0 if none within budget
   task automatic wait_pulse(input int which, output int edges);
      int i;
      edges = 0;
      i = 0;
      while (edges == 0 && i < 10) begin
         step(1);
         i++;
         if (pick_pulse(which)) edges = i;
      end
   endtask

   task automatic l_send(input logic [7:0] d, input bit expect_capture);
      l_bus = d;
      l_en  = 1'b1;
      if (expect_capture) l_q.push_back(d);
      step(6);
      l_en = 1'b0;
      step(4);
   endtask

   // Scoreboard side: every pulse must match the oldest expected word
   always @(negedge clk) begin
      if (rst_n && l_pulse) begin
         l_pcnt++;
         if (l_q.size() == 0) check("l_unexpected_pulse", l_pulse, 0);
         else check("l_sb_word", l_sbus, l_q.pop_front());
      end
      if (rst_n && t_pulse) begin
         t_pcnt++;
         if (t_q.size() == 0) check("t_unexpected_pulse", t_pulse, 0);
         else check("t_sb_word", t_sbus, t_q.pop_front());
      end
      if (rst_n && n_pulse) begin
         n_pcnt++;
         if (n_q.size() == 0) check("n_unexpected_pulse", n_pulse, 0);
         else check("n_sb_word", n_sbus, n_q.pop_front());
      end
   end

   initial begin
      int e;
      int p0;
      logic [7:0] d;
      rst_n = 1'b0;
      {l_bus, l_en, l_rdy, l_clr} = '0;
      {t_bus, t_en, t_rdy, t_clr} = '0;
      {n_bus, n_en, n_rdy, n_clr} = '0;
      step(2);
      check("rst_sbus", l_sbus, 8'h00);
      check("rst_pulse", l_pulse, 0);
      check("rst_valid", l_valid, 0);
      check("rst_ovr", l_ovr, 0);
      rst_n = 1'b1;
      step(6);

      // level transfer, ready high
      l_rdy = 1'b1;
      l_bus = 8'hA5;
      l_en  = 1'b1;
      l_q.push_back(8'hA5);
      wait_pulse(0, e);
      check("l_latency", e, 3);
      check("l_bus_a5", l_sbus, 8'hA5);
      check("l_valid_on", l_valid, 1);
      step(1);
      check("l_pulse_one_cycle", l_pulse, 0);
      check("l_valid_one_cycle", l_valid, 0);
      p0 = l_pcnt;
      l_en = 1'b0;
      step(8);
      check("l_fall_no_pulse", l_pcnt - p0, 0);
      check("l_bus_hold", l_sbus, 8'hA5);

      // backpressure: second word dropped
      p0 = l_pcnt;
      l_rdy = 1'b0;
      l_send(8'h11, 1'b1);
      l_send(8'h22, 1'b0);
      check("bp_bus", l_sbus, 8'h11);
      check("bp_valid", l_valid, 1);
      check("bp_ovr", l_ovr, 1);
      check("bp_single_pulse", l_pcnt - p0, 1);
      l_rdy = 1'b1;
      step(1);
      check("bp_accept_valid", l_valid, 0);
      check("bp_ovr_sticky", l_ovr, 1);
      l_clr = 1'b1;
      step(1);
      l_clr = 1'b0;
      check("bp_ovr_clr", l_ovr, 0);

      // accept and new event in the same cycle
      l_rdy = 1'b0;
      l_send(8'h44, 1'b1);
      check("sim_full", l_valid, 1);
      l_bus = 8'h33;
      l_en  = 1'b1;
      l_q.push_back(8'h33);
      step(2);
      l_rdy = 1'b1;
      step(1);
      check("sim_pulse", l_pulse, 1);
      check("sim_bus", l_sbus, 8'h33);
      check("sim_valid", l_valid, 1);
      check("sim_ovr", l_ovr, 0);
      step(1);
      check("sim_drain", l_valid, 0);
      l_en = 1'b0;
      step(4);

      // drop and overrun clear collide: set wins
      l_rdy = 1'b0;
      l_send(8'h55, 1'b1);
      l_bus = 8'h66;
      l_en  = 1'b1;
      step(2);
      l_clr = 1'b1;
      step(1);
      l_clr = 1'b0;
      check("col_ovr", l_ovr, 1);
      check("col_bus", l_sbus, 8'h55);
      l_rdy = 1'b1;
      step(1);
      check("col_drain", l_valid, 0);
      l_clr = 1'b1;
      step(1);
      l_clr = 1'b0;
      check("col_ovr_clr", l_ovr, 0);
      l_en = 1'b0;
      step(4);

      // three-stage chain
      n_rdy = 1'b1;
      n_bus = 8'hA5;
      n_en  = 1'b1;
      n_q.push_back(8'hA5);
      wait_pulse(2, e);
      check("n_latency", e, 4);
      check("n_bus", n_sbus, 8'hA5);
      step(1);
      check("n_pulse_one_cycle", n_pulse, 0);
      n_en = 1'b0;
      step(4);

      // toggle mode: fixed words then randomized ones
      t_rdy = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         d = (k <= 3) ? 8'(k) : 8'($urandom_range(0, 255));
         t_bus = d;
         t_en  = ~t_en;
         t_q.push_back(d);
         wait_pulse(1, e);
         check("t_latency", e, 3);
         check("t_bus", t_sbus, d);
         step((k <= 3) ? 2 : $urandom_range(1, 4));
      end
      check("t_pulse_count", t_pcnt, 9);

      // reset while a dropped event is in flight, release with enable high
      l_rdy = 1'b0;
      l_send(8'h88, 1'b1);
      l_bus = 8'h77;
      l_en  = 1'b1;
      step(2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sbus", l_sbus, 8'h00);
      check("mid_rst_valid", l_valid, 0);
      check("mid_rst_ovr", l_ovr, 0);
      check("mid_rst_pulse", l_pulse, 0);
      check("mid_rst_t_bus", t_sbus, 8'h00);
      check("mid_rst_n_bus", n_sbus, 8'h00);
      step(3);
      l_rdy = 1'b1;
      rst_n = 1'b1;
      p0 = l_pcnt;
      step(10);
      check("post_rst_no_pulse", l_pcnt - p0, 0);
      check("post_rst_valid", l_valid, 0);
      check("post_rst_ovr", l_ovr, 0);
      l_en = 1'b0;
      step(4);
      l_bus = 8'hBB;
      l_en  = 1'b1;
      l_q.push_back(8'hBB);
      wait_pulse(0, e);
      check("post_rst_latency", e, 3);
      check("post_rst_bus", l_sbus, 8'hBB);
      l_en = 1'b0;
      step(4);

      check("l_q_empty", l_q.size(), 0);
      check("t_q_empty", t_q.size(), 0);
      check("n_q_empty", n_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
